// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Purpose  : Receives a byte stream over valid/ready and packs it big-endian
//            into 32-bit instruction words. Each word is written to
//            sequential instruction-memory addresses. The processor is held
//            in reset until the whole program is loaded.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int ADDR_W         = 6,
    // Must be at least 1.
    parameter int CPU_RST_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_word_count,
    input  logic              i_in_valid,
    input  logic [7:0]        i_in_data,
    output logic              o_in_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_cpu_reset,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    // Largest legal word count: the full memory, 2^ADDR_W words.
    localparam logic [ADDR_W:0] c_WORD_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam int c_REL_W = (CPU_RST_CYCLES > 1) ? $clog2(CPU_RST_CYCLES) : 1;
    localparam logic [c_REL_W-1:0] c_REL_LAST = c_REL_W'(CPU_RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RECV    = 3'd1,
        S_WRITE   = 3'd2,
        S_RELEASE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W:0]     r_word_total;
    logic [ADDR_W-1:0]   r_word_idx;
    logic [1:0]          r_byte_cnt;
    logic [23:0]         r_shift;       // first three bytes of the current word
    logic [c_REL_W-1:0]  r_rel_cnt;

    logic                r_in_ready;
    logic                r_imem_we;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [31:0]         r_imem_wdata;
    logic                r_cpu_reset;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic                w_start_ok;
    logic                w_accept;
    logic                w_last_word;

    // A start is legal only for 1..2^ADDR_W words.
    assign w_start_ok  = (i_word_count != '0) && (i_word_count <= c_WORD_MAX);
    assign w_accept    = r_in_ready && i_in_valid;
    // The index is widened by one bit so a full-memory load ends at 2^ADDR_W-1 without wrapping.
    assign w_last_word = (({1'b0, r_word_idx} + (ADDR_W+1)'(1)) == r_word_total);

    // Loader FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_word_total <= '0;
            r_word_idx   <= '0;
            r_byte_cnt   <= '0;
            r_shift      <= '0;
            r_rel_cnt    <= '0;
            r_in_ready   <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_cpu_reset  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_err     <= 1'b0;
            r_imem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        if (w_start_ok) begin
                            r_word_total <= i_word_count;
                            r_word_idx   <= '0;
                            r_byte_cnt   <= '0;
                            r_rel_cnt    <= '0;
                            r_cpu_reset  <= 1'b1;
                            r_busy       <= 1'b1;
                            r_done       <= 1'b0;
                            r_in_ready   <= 1'b1;
                            r_state      <= S_RECV;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (w_accept) begin
                        if (r_byte_cnt == 2'd3) begin
                            r_imem_we    <= 1'b1;
                            r_imem_addr  <= r_word_idx;
                            r_imem_wdata <= {r_shift, i_in_data};
                            r_in_ready   <= 1'b0;
                            r_byte_cnt   <= '0;
                            r_state      <= S_WRITE;
                        end else begin
                            r_shift    <= {r_shift[15:0], i_in_data};
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_last_word) begin
                        r_state <= S_RELEASE;
                    end else begin
                        r_word_idx <= r_word_idx + 1'b1;
                        r_in_ready <= 1'b1;
                        r_state    <= S_RECV;
                    end
                end
                S_RELEASE: begin
                    if (r_rel_cnt == c_REL_LAST) begin
                        r_cpu_reset <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_rel_cnt <= r_rel_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_imem_we    = r_imem_we;
    assign o_imem_addr  = r_imem_addr;
    assign o_imem_wdata = r_imem_wdata;
    assign o_cpu_reset  = r_cpu_reset;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader. Expected writes go into a
//            scoreboard queue and are compared as imem_we pulses appear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int ADDR_W  = 6;
    localparam int RST_CYC = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic [ADDR_W:0]   i_word_count = '0;
    logic              i_in_valid = 1'b0;
    logic [7:0]        i_in_data = '0;
    logic              o_in_ready;
    logic              o_imem_we;
    logic [ADDR_W-1:0] o_imem_addr;
    logic [31:0]       o_imem_wdata;
    logic              o_cpu_reset;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    imem_loader #(.ADDR_W(ADDR_W), .CPU_RST_CYCLES(RST_CYC)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_word_count (i_word_count),
        .i_in_valid   (i_in_valid),
        .i_in_data    (i_in_data),
        .o_in_ready   (o_in_ready),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_wdata (o_imem_wdata),
        .o_cpu_reset  (o_cpu_reset),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         sb_q[$];
    logic [31:0] wq[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc = 0;
    int          last_we_cyc = 0;
    int          n_we = 0;
    logic        prev_cpu_rst = 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Write monitor: pops the scoreboard on every imem_we and times the release.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n) begin
            if (o_imem_we) begin
                n_we++;
                last_we_cyc = cyc;
                if (sb_q.size() == 0) begin
                    check("we_unexpected", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("we_addr", o_imem_addr, e.addr);
                    check("we_data", o_imem_wdata, e.data);
                end
            end
            if (prev_cpu_rst && !o_cpu_reset) begin
                check("release_latency", cyc - last_we_cyc, RST_CYC + 1);
                check("done_with_release", o_done, 1);
            end
        end
        prev_cpu_rst = o_cpu_reset;
    end

    task automatic do_start(input int n);
        i_start      = 1'b1;
        i_word_count = (ADDR_W+1)'(n);
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        i_in_valid = 1'b1;
        i_in_data  = b;
        @(negedge clk);
        while (!o_in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!o_in_ready) begin
            check("in_ready_timeout", 0, 1);
            i_in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gmax);
        int g;
        for (int k = 3; k >= 0; k--) begin
            send_byte(w[8*k +: 8]);
            g = (gmax > 0) ? $urandom_range(0, gmax) : 0;
            repeat (g) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (!o_done && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("done", o_done, 1);
        check("done_busy", o_busy, 0);
        check("done_cpu_reset", o_cpu_reset, 0);
        check("done_in_ready", o_in_ready, 0);
        check("sb_drained", sb_q.size(), 0);
    endtask

    task automatic run_load(input int gmax);
        int we0 = n_we;
        do_start(wq.size());
        check("start_busy", o_busy, 1);
        check("start_cpu_reset", o_cpu_reset, 1);
        check("start_done", o_done, 0);
        for (int i = 0; i < wq.size(); i++) begin
            sb_q.push_back('{addr: ADDR_W'(i), data: wq[i]});
            send_word(wq[i], gmax);
        end
        wait_done();
        check("we_count", n_we - we0, wq.size());
    endtask

    task automatic bad_start(input int n, input logic exp_done);
        int we0 = n_we;
        do_start(n);
        check("err_pulse", o_err, 1);
        check("err_busy", o_busy, 0);
        check("err_cpu_reset", o_cpu_reset, !exp_done);
        check("err_done", o_done, exp_done);
        @(posedge clk);
        #1;
        check("err_one_cycle", o_err, 0);
        check("err_no_write", n_we - we0, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, o_in_ready, 0);
        check({tag, "_we"}, o_imem_we, 0);
        check({tag, "_addr"}, o_imem_addr, 0);
        check({tag, "_wdata"}, o_imem_wdata, 0);
        check({tag, "_cpu_reset"}, o_cpu_reset, 1);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_err"}, o_err, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        logic [31:0] prog [0:5];
        prog[0] = 32'h20080005; prog[1] = 32'h2009000A; prog[2] = 32'h01095020;
        prog[3] = 32'hAC0A0000; prog[4] = 32'h8C0B0000; prog[5] = 32'h1000FFFF;

        // Power-on reset.
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Rejected starts from IDLE.
        bad_start(0, 1'b0);
        bad_start(65, 1'b0);

        // Single-word load with exact write and release timing.
        do_start(1);
        sb_q.push_back('{addr: '0, data: 32'h20080005});
        send_byte(8'h20);
        c0 = cyc;
        send_byte(8'h08);
        send_byte(8'h00);
        send_byte(8'h05);
        check("one_we_next_cycle", o_imem_we, 1);
        check("one_wdata", o_imem_wdata, 32'h20080005);
        @(posedge clk);
        #1;
        check("one_we_single", o_imem_we, 0);
        wait_done();
        check("one_done_cycles", cyc - c0 + 1, 4 + 1 + RST_CYC);

        // Six-word program, continuous and then with random gaps.
        wq.delete();
        for (int i = 0; i < 6; i++) wq.push_back(prog[i]);
        run_load(0);
        run_load(3);

        // Full-memory load: last write at address 2^ADDR_W-1.
        wq.delete();
        for (int i = 0; i < 64; i++) wq.push_back((32'(i) * 32'h01010101) ^ 32'hA5000000);
        run_load(0);

        // Reload from DONE with two words; starts during RECV are ignored.
        do_start(2);
        check("reload_cpu_reset", o_cpu_reset, 1);
        check("reload_done", o_done, 0);
        check("reload_busy", o_busy, 1);
        sb_q.push_back('{addr: 6'd0, data: 32'h11223344});
        sb_q.push_back('{addr: 6'd1, data: 32'h55667788});
        send_byte(8'h11);
        send_byte(8'h22);
        do_start(1);
        check("recv_start_no_err", o_err, 0);
        check("recv_start_busy", o_busy, 1);
        do_start(0);
        check("recv_badstart_no_err", o_err, 0);
        send_byte(8'h33);
        send_byte(8'h44);
        send_word(32'h55667788, 0);
        wait_done();

        // Invalid start in DONE.
        bad_start(100, 1'b1);

        // Reset in the middle of word 3.
        do_start(4);
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back('{addr: ADDR_W'(i), data: prog[i]});
            send_word(prog[i], 0);
        end
        send_byte(8'hCA);
        send_byte(8'hFE);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        check("midrst_sb_drained", sb_q.size(), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wq.delete();
        wq.push_back(32'hDEADBEEF);
        run_load(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
